// File: rtl/mbus_tx_queue_if.sv
// mbus_tx_queue_if: local push port plus MBus TX handshake between the queue (master) and its peers (slave).
interface mbus_tx_queue_if #(parameter int PTR_W = 2);
    logic             PUSH;
    logic [31:0]      ADDR_IN;
    logic [31:0]      DATA_IN;
    logic             FULL;
    logic             EMPTY;
    logic [PTR_W:0]   COUNT;
    logic             OVERFLOW;
    logic             SENT;
    logic             DROP;
    logic [31:0]      TX_ADDR;
    logic [31:0]      TX_DATA;
    logic             TX_REQ;
    logic             TX_PEND;
    logic             TX_PRIORITY;
    logic             TX_ACK;
    logic             TX_SUCC;
    logic             TX_FAIL;
    logic             TX_RESP_ACK;

    modport master (
        input  PUSH, ADDR_IN, DATA_IN, TX_ACK, TX_SUCC, TX_FAIL,
        output FULL, EMPTY, COUNT, OVERFLOW, SENT, DROP,
               TX_ADDR, TX_DATA, TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK
    );

    modport slave (
        output PUSH, ADDR_IN, DATA_IN, TX_ACK, TX_SUCC, TX_FAIL,
        input  FULL, EMPTY, COUNT, OVERFLOW, SENT, DROP,
               TX_ADDR, TX_DATA, TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK
    );
endinterface

// File: rtl/mbus_tx_queue.sv
// mbus_tx_queue: circular (addr,data) buffer drained over the MBus TX four-phase handshakes.
// Define MBUS_TXQ_RETRY_EN to re-request a failed entry up to MAX_RETRY extra times before dropping it.
module mbus_tx_queue #(
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic          CLK_EXT,
    input  logic          RESET,
    mbus_tx_queue_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] ACKW = 3'd2;
    localparam logic [2:0] RSLT = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    logic [31:0]      mem_addr [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [2:0]       state;
    logic             tx_req;
    logic             tx_resp_ack;
    logic             overflow;
    logic             sent;
    logic             drop;
    logic [31:0]      tx_addr;
    logic [31:0]      tx_data;
    logic             succ_q;
    logic             last_try;
    logic             push_ok;
    logic             resolve;
    logic             pop;

    assign push_ok = bus.PUSH && !bus.FULL;
    assign resolve = state == RESP && !bus.TX_SUCC && !bus.TX_FAIL;
    assign pop     = resolve && (succ_q || last_try);

`ifdef MBUS_TXQ_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_cnt;
    assign last_try = retry_cnt == RW'(MAX_RETRY);
    always_ff @(posedge CLK_EXT) begin
        if (RESET)
            retry_cnt <= '0;
        else if (resolve)
            retry_cnt <= pop ? '0 : retry_cnt + 1'b1;
    end
`else
    assign last_try = 1'b1;
`endif

    assign bus.FULL        = count == (PTR_W+1)'(DEPTH);
    assign bus.EMPTY       = count == '0;
    assign bus.COUNT       = count;
    assign bus.OVERFLOW    = overflow;
    assign bus.SENT        = sent;
    assign bus.DROP        = drop;
    assign bus.TX_ADDR     = tx_addr;
    assign bus.TX_DATA     = tx_data;
    assign bus.TX_REQ      = tx_req;
    assign bus.TX_RESP_ACK = tx_resp_ack;
    assign bus.TX_PEND     = 1'b0;
    assign bus.TX_PRIORITY = 1'b0;

    always_ff @(posedge CLK_EXT) begin
        if (push_ok) begin
            mem_addr[wr_ptr] <= bus.ADDR_IN;
            mem_data[wr_ptr] <= bus.DATA_IN;
        end
    end

    // The in-flight head stays counted until popped, so a push can never overwrite it.
    always_ff @(posedge CLK_EXT) begin
        if (RESET) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            state       <= IDLE;
            tx_req      <= 1'b0;
            tx_resp_ack <= 1'b0;
            overflow    <= 1'b0;
            sent        <= 1'b0;
            drop        <= 1'b0;
            tx_addr     <= '0;
            tx_data     <= '0;
            succ_q      <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + PTR_W'(push_ok);
            rd_ptr   <= rd_ptr + PTR_W'(pop);
            count    <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
            overflow <= bus.PUSH && bus.FULL;
            sent     <= pop && succ_q;
            drop     <= pop && !succ_q;
            case (state)
                IDLE: if (!bus.EMPTY) begin
                    tx_addr <= mem_addr[rd_ptr];
                    tx_data <= mem_data[rd_ptr];
                    tx_req  <= 1'b1;
                    state   <= REQ;
                end
                REQ: if (bus.TX_ACK) begin
                    tx_req <= 1'b0;
                    state  <= ACKW;
                end
                ACKW: if (!bus.TX_ACK) state <= RSLT;
                RSLT: if (bus.TX_SUCC || bus.TX_FAIL) begin
                    tx_resp_ack <= 1'b1;
                    succ_q      <= bus.TX_SUCC;
                    state       <= RESP;
                end
                RESP: if (resolve) begin
                    tx_resp_ack <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
